// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone classic single-access master.
// Accepts one command (address, data seed, byte select, direction, beat count)
// and plays it out as 1..16 separate classic transfers with incrementing
// addresses, separated by one idle cycle, then reports a completion response.
module wb_initiator #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  input  logic [3:0]  cmd_len,

  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,

  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [4:0]  rsp_beats,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Timeout fires when the counter has reached TIMEOUT-1 without an ack,
  // so a beat keeps cyc high for at most TIMEOUT cycles.
  localparam logic [TW-1:0] TLIMIT = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic          TO_EN  = (TIMEOUT != 0);

  state_t        state;
  state_t        state_nxt;

  logic          lat_we;
  logic [31:0]   lat_adr;
  logic [31:0]   lat_dat;
  logic [3:0]    lat_sel;
  logic [3:0]    lat_len;

  logic [4:0]    n;
  logic [TW-1:0] tcnt;
  logic          err;

  logic          rd_valid_q;
  logic [31:0]   rd_data_q;

  logic          accept;
  logic          acked;
  logic          last_beat;
  logic          timeout_hit;
  logic          in_req;

  assign in_req      = (state == REQ);
  assign accept      = cmd_valid && cmd_ready;
  assign acked       = in_req && wbm_ack_i;
  assign last_beat   = (n == {1'b0, lat_len});
  assign timeout_hit = TO_EN && in_req && !wbm_ack_i && (tcnt == TLIMIT);

  // State register; reset aborts any command in flight without a response.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: ack takes priority over a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (acked) begin
          state_nxt = last_beat ? DONE : GAP;
        end else if (timeout_hit) begin
          state_nxt = DONE;
        end
      end
      GAP:     state_nxt = REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch: inputs are only looked at on the accepting edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      lat_we  <= 1'b0;
      lat_adr <= '0;
      lat_dat <= '0;
      lat_sel <= '0;
      lat_len <= '0;
    end else if (accept) begin
      lat_we  <= cmd_we;
      lat_adr <= cmd_adr;
      lat_dat <= cmd_dat;
      lat_sel <= cmd_sel;
      lat_len <= cmd_len;
    end
  end

  // Beat index and sticky error flag for the current command.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      n   <= '0;
      err <= 1'b0;
    end else if (accept) begin
      n   <= '0;
      err <= 1'b0;
    end else begin
      if (acked) begin
        n <= n + 5'd1;
      end
      if (timeout_hit) begin
        err <= 1'b1;
      end
    end
  end

  // Per-beat timeout counter: counts unacked REQ cycles, idle otherwise.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tcnt <= '0;
    end else if (in_req && !wbm_ack_i) begin
      tcnt <= tcnt + TW'(1);
    end else begin
      tcnt <= '0;
    end
  end

  // Read return: capture slave data on an acked read beat, pulse next cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= acked && !lat_we;
      if (acked && !lat_we) begin
        rd_data_q <= wbm_dat_i;
      end
    end
  end

  assign cmd_ready = (state == IDLE) && !wb_rst_i;
  assign busy      = (state != IDLE);

  assign wbm_cyc_o = in_req;
  assign wbm_stb_o = in_req;
  assign wbm_we_o  = in_req && lat_we;
  assign wbm_sel_o = in_req ? lat_sel : 4'd0;
  assign wbm_adr_o = in_req ? (lat_adr + {25'd0, n, 2'b00}) : 32'd0;
  assign wbm_dat_o = (in_req && lat_we) ? (lat_dat + {27'd0, n}) : 32'd0;

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

  assign rsp_valid = (state == DONE);
  assign rsp_err   = (state == DONE) && err;
  assign rsp_beats = (state == DONE) ? n : 5'd0;

endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: scoreboard bench for wb_initiator.
// Stimulus pushes expected beats, read data and responses into queues; a
// monitor pops and compares whenever the DUT presents the matching output.
module tb_wb_initiator;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic [3:0]  cmd_len;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rsp_valid;
  logic        rsp_err;
  logic [4:0]  rsp_beats;
  logic        busy;

  wb_initiator #(.TIMEOUT(8), .TW(8)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .cmd_len  (cmd_len),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .rsp_beats(rsp_beats),
    .busy     (busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          cyc_len;
    int          gap;
  } beat_t;

  typedef struct {
    logic       err;
    logic [4:0] beats;
  } rsp_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_rd[$];
  rsp_t        exp_rsp[$];

  int errors = 0;
  int checks = 0;
  int beat_rises = 0;

  int          ack_wait   = 0;
  logic        ack_enable = 1'b1;
  logic        stray_ack  = 1'b0;
  logic [31:0] slave_dat  = 32'h0;

  // Free-running clock, 10 time units per cycle.
  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  // Hard stop in case something never settles.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportUnexpected(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: output seen with nothing expected at %0t", name, $time);
  endtask

  task automatic pushBeat(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int cyc_len, input int gap);
    beat_t b;
    b.we = we; b.adr = adr; b.dat = dat; b.sel = sel; b.cyc_len = cyc_len; b.gap = gap;
    exp_beats.push_back(b);
  endtask

  task automatic pushRsp(input logic err, input logic [4:0] beats);
    rsp_t r;
    r.err = err; r.beats = beats;
    exp_rsp.push_back(r);
  endtask

  // Drive one command and return just after the accepting edge.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic [3:0] len);
    int guard = 0;
    @(negedge wb_clk_i);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_len   = len;
    while (!cmd_ready && guard < 100) begin
      @(negedge wb_clk_i);
      guard++;
    end
    if (guard >= 100) begin
      reportUnexpected("cmd_accept_timeout");
    end
    @(posedge wb_clk_i);
    #1;
    cmd_valid = 1'b0;
    cmd_we    = ~we;
    cmd_adr   = 32'h5555_AAAA;
    cmd_dat   = 32'h0BAD_F00D;
    cmd_sel   = 4'h0;
    cmd_len   = 4'hF;
  endtask

  // Wait until the DUT is back in IDLE, bounded.
  task automatic waitIdle(input string name);
    int guard = 0;
    @(negedge wb_clk_i);
    while (!(cmd_ready && !busy) && guard < 300) begin
      @(negedge wb_clk_i);
      guard++;
    end
    if (guard >= 300) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: idle wait expired, busy=%0b cmd_ready=%0b", name, busy, cmd_ready);
    end
  endtask

  // Responder model: acks after ack_wait cycles of cyc, optional stray acks when cyc is low.
  initial begin
    int hold_cnt = 0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    forever begin
      @(negedge wb_clk_i);
      if (wbm_cyc_o) begin
        if (ack_enable && hold_cnt == ack_wait) begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = slave_dat;
          slave_dat = slave_dat + 32'd1;
        end else begin
          wbm_ack_i = 1'b0;
          wbm_dat_i = 32'h0;
        end
        hold_cnt++;
      end else begin
        hold_cnt  = 0;
        wbm_ack_i = stray_ack;
        wbm_dat_i = stray_ack ? 32'hDEAD_BEEF : 32'h0;
      end
    end
  end

  // Monitor: compares bus beats, read returns and responses against the queues.
  initial begin
    logic  prev_cyc = 1'b0;
    int    low_run  = 0;
    int    high_run = 0;
    logic  have_cur = 1'b0;
    beat_t cur;
    rsp_t  r;
    logic [31:0] d;
    forever begin
      @(negedge wb_clk_i);
      if (wbm_cyc_o && !prev_cyc) begin
        beat_rises++;
        high_run = 0;
        if (exp_beats.size() == 0) begin
          reportUnexpected("beat");
          have_cur = 1'b0;
        end else begin
          cur = exp_beats.pop_front();
          have_cur = 1'b1;
          checkOutput("beat_adr", wbm_adr_o, cur.adr);
          checkOutput("beat_dat", wbm_dat_o, cur.dat);
          checkOutput("beat_we",  32'(wbm_we_o), 32'(cur.we));
          checkOutput("beat_sel", 32'(wbm_sel_o), 32'(cur.sel));
          checkOutput("beat_stb", 32'(wbm_stb_o), 32'd1);
          if (cur.gap != 0) begin
            checkOutput("beat_gap", 32'(low_run), 32'(cur.gap));
          end
        end
      end
      if (!wbm_cyc_o && prev_cyc) begin
        if (have_cur && cur.cyc_len != 0) begin
          checkOutput("cyc_len", 32'(high_run), 32'(cur.cyc_len));
        end
        have_cur = 1'b0;
        low_run  = 0;
      end
      if (wbm_cyc_o) high_run++; else low_run++;
      prev_cyc = wbm_cyc_o;

      if (rd_valid) begin
        if (exp_rd.size() == 0) begin
          reportUnexpected("rd_valid");
        end else begin
          d = exp_rd.pop_front();
          checkOutput("rd_data", rd_data, d);
        end
      end

      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          reportUnexpected("rsp_valid");
        end else begin
          r = exp_rsp.pop_front();
          checkOutput("rsp_err",   32'(rsp_err),   32'(r.err));
          checkOutput("rsp_beats", 32'(rsp_beats), 32'(r.beats));
        end
      end
    end
  end

  // Directed test sequence.
  initial begin
    int base;
    int guard;
    wb_rst_i  = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h0;
    cmd_dat   = 32'h0;
    cmd_sel   = 4'h0;
    cmd_len   = 4'h0;

    repeat (3) @(posedge wb_clk_i);
    #1;
    checkOutput("reset_cmd_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i);
    #1;
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_busy",      32'(busy),      32'd0);
    checkOutput("reset_cyc",       32'(wbm_cyc_o), 32'd0);
    checkOutput("reset_adr",       wbm_adr_o,      32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rd_valid",  32'(rd_valid),  32'd0);

    $display("[TB] single write");
    ack_wait = 1;
    pushBeat(1'b1, 32'h3000_0000, 32'h1234_5678, 4'hF, 2, 0);
    pushRsp(1'b0, 5'd1);
    applyStimulus(1'b1, 32'h3000_0000, 32'h1234_5678, 4'hF, 4'd0);
    waitIdle("single_write");

    $display("[TB] 4-beat read");
    ack_wait  = 0;
    slave_dat = 32'hA0;
    for (int i = 0; i < 4; i++) begin
      pushBeat(1'b0, 32'h3000_0010 + 32'(4 * i), 32'h0, 4'hF, 1, (i == 0) ? 0 : 1);
      exp_rd.push_back(32'hA0 + 32'(i));
    end
    pushRsp(1'b0, 5'd4);
    applyStimulus(1'b0, 32'h3000_0010, 32'h0, 4'hF, 4'd3);
    waitIdle("read4");

    $display("[TB] timeout");
    ack_enable = 1'b0;
    pushBeat(1'b0, 32'h3000_0020, 32'h0, 4'hF, 8, 0);
    pushRsp(1'b1, 5'd0);
    applyStimulus(1'b0, 32'h3000_0020, 32'h0, 4'hF, 4'd2);
    waitIdle("timeout");
    ack_enable = 1'b1;

    $display("[TB] address/data wrap");
    pushBeat(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h3, 1, 0);
    pushBeat(1'b1, 32'h0000_0000, 32'h0000_0000, 4'h3, 1, 1);
    pushRsp(1'b0, 5'd2);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h3, 4'd1);
    waitIdle("wrap");

    $display("[TB] stray acks and input changes while busy");
    stray_ack = 1'b1;
    repeat (4) @(negedge wb_clk_i);
    checkOutput("stray_idle_busy", 32'(busy), 32'd0);
    slave_dat = 32'hB0;
    for (int i = 0; i < 3; i++) begin
      pushBeat(1'b0, 32'h3000_0040 + 32'(4 * i), 32'h0, 4'h5, 1, (i == 0) ? 0 : 1);
      exp_rd.push_back(32'hB0 + 32'(i));
    end
    pushRsp(1'b0, 5'd3);
    applyStimulus(1'b0, 32'h3000_0040, 32'h0, 4'h5, 4'd2);
    waitIdle("stray");
    stray_ack = 1'b0;

    $display("[TB] reset mid-burst");
    ack_wait = 3;
    for (int i = 0; i < 3; i++) begin
      pushBeat(1'b1, 32'h3000_0200 + 32'(4 * i), 32'h0000_1000 + 32'(i), 4'hF,
               (i < 2) ? 4 : 0, (i == 0) ? 0 : 1);
    end
    base = beat_rises;
    applyStimulus(1'b1, 32'h3000_0200, 32'h0000_1000, 4'hF, 4'd5);
    guard = 0;
    while (beat_rises < base + 3 && guard < 200) begin
      @(negedge wb_clk_i);
      guard++;
    end
    if (guard >= 200) begin
      reportUnexpected("reset_burst_wait_expired");
    end
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    checkOutput("abort_cyc",       32'(wbm_cyc_o), 32'd0);
    checkOutput("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("abort_busy",      32'(busy),      32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    #1;
    checkOutput("abort_ready_after", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge wb_clk_i);

    $display("[TB] minimum-latency single beat");
    ack_wait = 0;
    pushBeat(1'b1, 32'h3000_0100, 32'hCAFE_0001, 4'hF, 1, 0);
    pushRsp(1'b0, 5'd1);
    applyStimulus(1'b1, 32'h3000_0100, 32'hCAFE_0001, 4'hF, 4'd0);
    checkOutput("lat_t1_cyc", 32'(wbm_cyc_o), 32'd1);
    @(posedge wb_clk_i);
    #1;
    checkOutput("lat_t2_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("lat_t2_cyc",       32'(wbm_cyc_o), 32'd0);
    @(posedge wb_clk_i);
    #1;
    checkOutput("lat_t3_cmd_ready", 32'(cmd_ready), 32'd1);

    repeat (4) @(negedge wb_clk_i);
    checkOutput("beats_left", 32'(exp_beats.size()), 32'd0);
    checkOutput("rd_left",    32'(exp_rd.size()),    32'd0);
    checkOutput("rsp_left",   32'(exp_rsp.size()),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
